// File: rtl/mux_pkg.sv
// Shared constants for the operand-forwarding selectors.
// Holds the forwarding select encodings and the default data width.
package mux_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_WB    = 2'd1,
        FWD_EXMEM = 2'd2,
        FWD_IMM   = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N:1 selector over a packed bus.
// Also flags whether the select index addresses a real input.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter  int WIDTH = DATA_W,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]   select_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               in_range_o
);

    // One extra bit so that N itself is representable when N is a power of two.
    localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(N);

    assign in_range_o = ({1'b0, select_i} < N_L);

    // An unknown or out-of-range index matches nothing and yields zero.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < N; k++) begin
            if (select_i == SEL_W'(k)) begin
                data_o = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// ID/EX operand selector: N:1 select followed by one register stage with
// valid tracking, stall (hold), flush (bubble) and a sticky range error.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = DATA_W,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]   select_i,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    output logic               sel_err_o
);

    logic [WIDTH-1:0] sel_data;
    logic             in_range;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_mux (
        .data_i     (data_i),
        .select_i   (select_i),
        .data_o     (sel_data),
        .in_range_o (in_range)
    );

    // Flush beats stall; gating on valid_i keeps an unknown select off data_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            sel_err_o <= 1'b0;
        end else if (flush_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o <= valid_i;
            if (valid_i && in_range) begin
                data_o <= sel_data;
            end else begin
                data_o <= '0;
            end
            if (valid_i && !in_range) begin
                sel_err_o <= 1'b1;
            end
        end
    end

endmodule
